// File: rtl/rangefinder_sopc_status_pio.sv
// Avalon-MM status input port: synchronises, debounces and edge-captures up to
// 32 asynchronous status lines, with a per-bit maskable level interrupt.
module rangefinder_sopc_status_pio #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DATA_W   = 32;
  localparam logic [1:0]  ADDR_DAT = 2'd0;
  localparam logic [1:0]  ADDR_MSK = 2'd2;
  localparam logic [1:0]  ADDR_EDG = 2'd3;

  logic [WIDTH-1:0]  r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]  r_stable;
  logic [WIDTH-1:0]  r_prev;
  logic [WIDTH-1:0]  r_edge_cap;
  logic [WIDTH-1:0]  r_irq_mask;
  logic [DATA_W-1:0] r_readdata;
  logic              r_irq;

  logic [WIDTH-1:0]  w_sync;
  logic [WIDTH-1:0]  w_edge;
  logic [WIDTH-1:0]  w_clr;
  logic [WIDTH-1:0]  w_edge_cap_next;
  logic [WIDTH-1:0]  w_irq_mask_next;
  logic              w_wr;
  logic              w_unused_wdata;

  // Bits of writedata above WIDTH are deliberately ignored.
  assign w_unused_wdata = &{1'b0, writedata};

  // Multi-flop synchroniser per input bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int s = 1; s < int'(SYNC_STAGES); s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_stable <= '0;
        else          r_stable <= w_sync;
      end
    end else begin : g_debounce
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
      logic [CNT_W-1:0] r_cnt [WIDTH];

      // A new level is accepted only after it has held for DEBOUNCE_CYCLES.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stable <= '0;
          for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            if (w_sync[i] == r_stable[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
              r_stable[i] <= w_sync[i];
              r_cnt[i]    <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = r_stable & ~r_prev;
      1:       w_edge = ~r_stable & r_prev;
      default: w_edge = r_stable ^ r_prev;
    endcase
  end

  assign w_wr = chipselect & ~write_n;

  // A set from a detected edge overrides a same-cycle write-1-to-clear.
  always_comb begin
    w_clr           = '0;
    w_irq_mask_next = r_irq_mask;
    if (w_wr && (address == ADDR_EDG)) w_clr = writedata[WIDTH-1:0];
    if (w_wr && (address == ADDR_MSK)) w_irq_mask_next = writedata[WIDTH-1:0];
    w_edge_cap_next = (r_edge_cap & ~w_clr) | w_edge;
  end

  // irq is registered from the next-state values so it moves on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev     <= '0;
      r_edge_cap <= '0;
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_prev     <= r_stable;
      r_edge_cap <= w_edge_cap_next;
      r_irq_mask <= w_irq_mask_next;
      r_irq      <= |(w_edge_cap_next & w_irq_mask_next);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      case (address)
        ADDR_DAT: r_readdata <= DATA_W'(r_stable);
        ADDR_MSK: r_readdata <= DATA_W'(r_irq_mask);
        ADDR_EDG: r_readdata <= DATA_W'(r_edge_cap);
        default:  r_readdata <= '0;
      endcase
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule
